// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch PC with load, relative branch and call/return via a
// hardware return-address stack. Define PC_STACK_ERR_EN to enable the sticky
// stack-fault flag on err; without it err is tied low.
module program_counter_stack #(
   parameter int             W         = 8,
   parameter int             DEPTH     = 4,
   parameter int             STEP      = 1,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     load,
   input  logic                     call,
   input  logic                     ret,
   input  logic                     branch,
   input  logic [W-1:0]             data,
   input  logic [W-1:0]             offset,
   output logic [W-1:0]             out,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     stack_full,
   output logic                     stack_empty,
   output logic                     err
);
   localparam int            AW     = $clog2(DEPTH);
   localparam int            SPW    = AW + 1;
   localparam logic [W-1:0]  STEP_W = W'(STEP);

   logic [W-1:0]    out_q, out_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            err_q, err_d;
   logic [W-1:0]    stack_q [DEPTH];

   logic            is_full, is_empty;
   logic            do_load, do_call, do_ret, do_branch;
   logic            push, pop;
   logic [SPW-1:0]  sp_m1;
   logic [AW-1:0]   wr_idx, rd_idx;
   logic [W-1:0]    seq_pc;

   // Priority decode of the command and next-state of PC, pointer and flags.
   // A ret on an empty stack falls through to the sequential increment.
   always_comb begin
      is_full   = sp_q == SPW'(DEPTH);
      is_empty  = sp_q == '0;
      do_load   = enable & load;
      do_call   = enable & ~load & call;
      do_ret    = enable & ~load & ~call & ret;
      do_branch = enable & ~load & ~call & ~ret & branch;
      push      = do_call & ~is_full;
      pop       = do_ret & ~is_empty;
      sp_m1     = sp_q - SPW'(1);
      wr_idx    = sp_q[AW-1:0];
      rd_idx    = sp_m1[AW-1:0];
      seq_pc    = out_q + STEP_W;
      out_d     = ~enable             ? out_q :
                  (do_load | do_call) ? data :
                  pop                 ? stack_q[rd_idx] :
                  do_branch           ? out_q + offset :
                                        seq_pc;
      sp_d      = push ? sp_q + SPW'(1) : pop ? sp_m1 : sp_q;
      full_d    = sp_d == SPW'(DEPTH);
      empty_d   = sp_d == '0;
`ifdef PC_STACK_ERR_EN
      err_d     = err_q | (do_call & is_full) | (do_ret & is_empty);
`else
      err_d     = 1'b0;
`endif
   end

   // PC, stack pointer and status flags, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q   <= RESET_VAL;
         sp_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         sp_q    <= sp_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) stack_q[wr_idx] <= seq_pc;
   end

   assign out         = out_q;
   assign sp          = sp_q;
   assign stack_full  = full_q;
   assign stack_empty = empty_q;
   assign err         = err_q;
endmodule
